drive_sequencer: RTL and testbench
==================================

Name: drive_sequencer

Overview:
- Sits between the line-following direction decoder and the motor H-bridges.
- Turns the 4-bit steering code (DIR) into left/right PWM duty and motor-direction bits, and drives the travel-direction bit back into the decoder.
- Times pivot turns and sequences end-of-line stops into a programmable number of out-and-back laps.
- One PWM counter is shared by both channels.

Parameters:
- PWM_PERIOD, 1000: PWM counter period in clk cycles; counter width is clog2(PWM_PERIOD).
- DUTY_FULL, 900: duty for straight drive and the outer wheel when veering.
- DUTY_VEER, 500: inner-wheel duty for VEER codes.
- DUTY_TURN, 600: duty for both wheels during a 90-degree pivot.
- TURN_MIN, 25_000_000: minimum clk cycles a pivot is held (500 ms at 50 MHz).
- SETTLE_TICKS, 50_000_000: stationary dwell in HALT before reversing.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- go  in  1  start pulse; latches laps, leaves IDLE or DONE.
- laps  in  4  number of direction reversals to perform after the first stop.
- dir_code  in  4  steering code: 0000 PROCEED, 1001 VEER_RIGHT, 1010 HARD_RIGHT, 1011 NINETY_RIGHT, 0101 VEER_LEFT, 0110 HARD_LEFT, 0111 NINETY_LEFT, 1111 STOP.
- direction  out  1  travel direction to decoder: 1 FORWARDS, 0 BACKWARDS.
- pwm_l, pwm_r  out  1  motor PWM.
- mdir_l, mdir_r  out  1  motor direction: 1 wheel forward, 0 wheel reverse.
- busy  out  1  high in DRIVE, TURN, HALT.
- done  out  1  high in DONE.

Behaviour:
- Reset values: state IDLE, all counters 0, pwm_l=pwm_r=0, duty registers 0, mdir_l=mdir_r=1, direction=1, busy=0, done=0.
- Input sampling: dir_code is registered once (code_q). All decisions use code_q, so the state changes 2 cycles after a dir_code edge.
- Undefined codes (any code not in the list above) are treated as STOP.
- PWM:
  - The counter runs 0..PWM_PERIOD-1 and wraps.
  - pwm_x = (cnt < duty_x_active).
  - duty_x_active and mdir_x_active load from the next-value registers only on the wrap cycle (cnt == PWM_PERIOD-1), so there are no mid-period glitches.
  - Exception: entering HALT or IDLE, or reset, zeroes duty_active and forces pwm low on the same cycle (safety override).
- State machine:
  - IDLE: outputs zero. On go: laps_left<=laps, direction<=1, enter DRIVE.
  - DRIVE, by code_q:
    - PROCEED: both wheels DUTY_FULL.
    - VEER_L: left DUTY_VEER, right DUTY_FULL (mirror for VEER_R).
    - HARD_L: left 0, right DUTY_FULL (mirror for HARD_R).
    - NINETY_x: clear turn_cnt, enter TURN.
    - STOP or undefined: enter HALT.
  - TURN:
    - NINETY_LEFT pivot: left DUTY_TURN reverse, right DUTY_TURN forward (mirror for right).
    - The turn side is latched on entry.
    - turn_cnt increments every cycle, saturating at TURN_MIN.
    - Exit to DRIVE when turn_cnt==TURN_MIN and code_q is a non-NINETY drive code.
    - A NINETY code of either side after TURN_MIN keeps the latched pivot.
    - STOP goes to HALT immediately, regardless of turn_cnt.
  - HALT:
    - Both duties 0.
    - settle_cnt counts to SETTLE_TICKS-1.
    - At that count: if laps_left != 0, toggle direction, decrement laps_left, enter DRIVE; else enter DONE.
  - DONE: done=1, outputs zero. go restarts exactly as from IDLE.
- Backwards travel: when direction=0, both mdir bits are inverted relative to the forwards table; duties are unchanged.
- Simultaneous events:
  - go is ignored in DRIVE, TURN and HALT.
  - reset overrides everything.
  - Reset mid-turn returns to IDLE with PWM low on the next cycle.
- Counter widths: turn_cnt is clog2(TURN_MIN+1) bits and settle_cnt is clog2(SETTLE_TICKS) bits. Neither counter wraps.

Decomposition:
- Shared package holds:
  - DIR code constants, identical values to the decoder's.
  - FORWARDS/BACKWARDS.
  - State encoding: IDLE, DRIVE, TURN, HALT, DONE.
- One sub-module, pwm_pair:
  - Owns the shared counter, the wrap-synchronous duty/mdir load and the zero override.
  - Drives pwm_l/pwm_r and mdir_l/mdir_r.
- The FSM and timers stay in drive_sequencer.

Test Plan (overrides PWM_PERIOD=10, DUTY_FULL=8, DUTY_VEER=4, DUTY_TURN=6, TURN_MIN=40, SETTLE_TICKS=20):
1. reset, go, laps=0, dir_code=0000 -> busy=1; from the first wrap, pwm_l and pwm_r high 8 of every 10 cycles; mdir both 1; direction=1.
2. In DRIVE, dir_code=0101 mid-period -> duties unchanged until the wrap, then left high 4/10 and right 8/10.
3. dir_code=0111 for 10 cycles, then 0000 -> pivot held with mdir_l=0, mdir_r=1 at 6/10 until turn_cnt==40; DRIVE resumes only after 40 cycles in TURN.
4. go, laps=1, STOP -> pwm low the same cycle; after 20 cycles direction=0, state DRIVE with PROCEED giving mdir both 0. Second STOP plus 20 cycles -> done=1, busy=0.
5. dir_code=0001 in DRIVE -> treated as STOP: enters HALT, pwm forced low.
6. Assert reset for 1 cycle during TURN -> next cycle IDLE, pwm 0, mdir 1, direction 1; go is ignored while busy.

Source files
------------

// File: rtl/drive_sequencer_pkg.sv
// Shared definitions for the drive sequencer: steering codes, travel direction, FSM encoding.
`default_nettype none

package drive_sequencer_pkg;

  localparam logic [3:0] DIR_PROCEED      = 4'b0000;
  localparam logic [3:0] DIR_VEER_RIGHT   = 4'b1001;
  localparam logic [3:0] DIR_HARD_RIGHT   = 4'b1010;
  localparam logic [3:0] DIR_NINETY_RIGHT = 4'b1011;
  localparam logic [3:0] DIR_VEER_LEFT    = 4'b0101;
  localparam logic [3:0] DIR_HARD_LEFT    = 4'b0110;
  localparam logic [3:0] DIR_NINETY_LEFT  = 4'b0111;
  localparam logic [3:0] DIR_STOP         = 4'b1111;

  localparam logic FORWARDS  = 1'b1;
  localparam logic BACKWARDS = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRIVE = 3'd1,
    ST_TURN  = 3'd2,
    ST_HALT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    CMD_PROCEED  = 3'd0,
    CMD_VEER_L   = 3'd1,
    CMD_VEER_R   = 3'd2,
    CMD_HARD_L   = 3'd3,
    CMD_HARD_R   = 3'd4,
    CMD_NINETY_L = 3'd5,
    CMD_NINETY_R = 3'd6,
    CMD_STOP     = 3'd7
  } cmd_t;

  // Anything the decoder should never emit is handled as a stop.
  function automatic cmd_t decode_dir(input logic [3:0] code);
    case (code)
      DIR_PROCEED:      return CMD_PROCEED;
      DIR_VEER_LEFT:    return CMD_VEER_L;
      DIR_VEER_RIGHT:   return CMD_VEER_R;
      DIR_HARD_LEFT:    return CMD_HARD_L;
      DIR_HARD_RIGHT:   return CMD_HARD_R;
      DIR_NINETY_LEFT:  return CMD_NINETY_L;
      DIR_NINETY_RIGHT: return CMD_NINETY_R;
      default:          return CMD_STOP;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/drive_sequencer_pwm_pair.sv
// Shared PWM counter for both motor channels; duty and direction update only at the period wrap.
`default_nettype none

module pwm_pair #(
  parameter int PWM_PERIOD = 1000,
  parameter int DUTY_W     = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              zero,
  input  logic [DUTY_W-1:0] duty_l_next,
  input  logic [DUTY_W-1:0] duty_r_next,
  input  logic              mdir_l_next,
  input  logic              mdir_r_next,
  output logic              pwm_l,
  output logic              pwm_r,
  output logic              mdir_l,
  output logic              mdir_r
);

  localparam int CNT_W = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PWM_PERIOD - 1);

  logic [CNT_W-1:0]  cnt;
  logic [DUTY_W-1:0] duty_l;
  logic [DUTY_W-1:0] duty_r;
  logic              wrap;

  assign wrap = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      duty_l <= '0;
      duty_r <= '0;
      mdir_l <= 1'b1;
      mdir_r <= 1'b1;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      // zero is driven from the FSM's next state, so pwm is already low in the first stopped cycle.
      if (zero) begin
        duty_l <= '0;
        duty_r <= '0;
      end else if (wrap) begin
        duty_l <= duty_l_next;
        duty_r <= duty_r_next;
      end
      if (wrap) begin
        mdir_l <= mdir_l_next;
        mdir_r <= mdir_r_next;
      end
    end
  end

  assign pwm_l = (DUTY_W'(cnt) < duty_l);
  assign pwm_r = (DUTY_W'(cnt) < duty_r);

endmodule

`default_nettype wire

// File: rtl/drive_sequencer.sv
// Steering-code to motor sequencer: drive/veer/pivot control, end-of-line halts and out-and-back laps.
`default_nettype none

module drive_sequencer
  import drive_sequencer_pkg::*;
#(
  parameter int PWM_PERIOD   = 1000,
  parameter int DUTY_FULL    = 900,
  parameter int DUTY_VEER    = 500,
  parameter int DUTY_TURN    = 600,
  parameter int TURN_MIN     = 25_000_000,
  parameter int SETTLE_TICKS = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic [3:0] laps,
  input  logic [3:0] dir_code,
  output logic       direction,
  output logic       pwm_l,
  output logic       pwm_r,
  output logic       mdir_l,
  output logic       mdir_r,
  output logic       busy,
  output logic       done
);

  localparam int DUTY_W   = $clog2(PWM_PERIOD + 1);
  localparam int TURN_W   = (TURN_MIN > 0) ? $clog2(TURN_MIN + 1) : 1;
  localparam int SETTLE_W = (SETTLE_TICKS > 1) ? $clog2(SETTLE_TICKS) : 1;

  localparam logic [DUTY_W-1:0]   D_FULL      = DUTY_W'(DUTY_FULL);
  localparam logic [DUTY_W-1:0]   D_VEER      = DUTY_W'(DUTY_VEER);
  localparam logic [DUTY_W-1:0]   D_TURN      = DUTY_W'(DUTY_TURN);
  localparam logic [TURN_W-1:0]   TURN_LAST   = TURN_W'(TURN_MIN);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_TICKS - 1);

  state_t              state;
  state_t              state_next;
  logic [3:0]          code_q;
  cmd_t                cmd;
  logic [TURN_W-1:0]   turn_cnt;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [3:0]          laps_left;
  logic                turn_left;
  logic                turn_done;
  logic                settle_done;
  logic                is_ninety;
  logic                zero;

  logic [DUTY_W-1:0]   duty_l_next;
  logic [DUTY_W-1:0]   duty_r_next;
  logic                fwd_l;
  logic                fwd_r;
  logic                mdir_l_next;
  logic                mdir_r_next;

  assign cmd         = decode_dir(code_q);
  assign is_ninety   = (cmd == CMD_NINETY_L) || (cmd == CMD_NINETY_R);
  assign turn_done   = (turn_cnt == TURN_LAST);
  assign settle_done = (settle_cnt == SETTLE_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      code_q     <= '0;
      turn_cnt   <= '0;
      settle_cnt <= '0;
      laps_left  <= '0;
      turn_left  <= 1'b0;
      direction  <= FORWARDS;
    end else begin
      state  <= state_next;
      code_q <= dir_code;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (go) begin
            laps_left <= laps;
            direction <= FORWARDS;
          end
        end
        ST_DRIVE: begin
          turn_cnt   <= '0;
          settle_cnt <= '0;
          if (is_ninety) turn_left <= (cmd == CMD_NINETY_L);
        end
        ST_TURN: begin
          settle_cnt <= '0;
          if (!turn_done) turn_cnt <= turn_cnt + 1'b1;
        end
        ST_HALT: begin
          if (settle_done) begin
            if (laps_left != 4'd0) begin
              direction <= ~direction;
              laps_left <= laps_left - 4'd1;
            end
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE: if (go) state_next = ST_DRIVE;
      ST_DRIVE: begin
        if (cmd == CMD_STOP)  state_next = ST_HALT;
        else if (is_ninety)   state_next = ST_TURN;
      end
      ST_TURN: begin
        // A stop aborts the pivot at once; any other code must wait out the minimum pivot time.
        if (cmd == CMD_STOP)              state_next = ST_HALT;
        else if (turn_done && !is_ninety) state_next = ST_DRIVE;
      end
      ST_HALT: begin
        if (settle_done) state_next = (laps_left != 4'd0) ? ST_DRIVE : ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    duty_l_next = '0;
    duty_r_next = '0;
    fwd_l       = 1'b1;
    fwd_r       = 1'b1;
    case (state)
      ST_DRIVE: begin
        case (cmd)
          CMD_PROCEED:  begin duty_l_next = D_FULL; duty_r_next = D_FULL; end
          CMD_VEER_L:   begin duty_l_next = D_VEER; duty_r_next = D_FULL; end
          CMD_VEER_R:   begin duty_l_next = D_FULL; duty_r_next = D_VEER; end
          CMD_HARD_L:   begin duty_l_next = '0;     duty_r_next = D_FULL; end
          CMD_HARD_R:   begin duty_l_next = D_FULL; duty_r_next = '0;     end
          CMD_NINETY_L: begin duty_l_next = D_TURN; duty_r_next = D_TURN; fwd_l = 1'b0; end
          CMD_NINETY_R: begin duty_l_next = D_TURN; duty_r_next = D_TURN; fwd_r = 1'b0; end
          default: ;
        endcase
      end
      ST_TURN: begin
        duty_l_next = D_TURN;
        duty_r_next = D_TURN;
        if (turn_left) fwd_l = 1'b0;
        else           fwd_r = 1'b0;
      end
      default: ;
    endcase
    if ((state == ST_DRIVE || state == ST_TURN) && direction == BACKWARDS) begin
      mdir_l_next = ~fwd_l;
      mdir_r_next = ~fwd_r;
    end else begin
      mdir_l_next = fwd_l;
      mdir_r_next = fwd_r;
    end
    busy = (state == ST_DRIVE) || (state == ST_TURN) || (state == ST_HALT);
    done = (state == ST_DONE);
  end

  assign zero = (state_next == ST_IDLE) || (state_next == ST_HALT) || (state_next == ST_DONE);

  pwm_pair #(
    .PWM_PERIOD (PWM_PERIOD),
    .DUTY_W     (DUTY_W)
  ) u_pwm_pair (
    .clk         (clk),
    .reset       (reset),
    .zero        (zero),
    .duty_l_next (duty_l_next),
    .duty_r_next (duty_r_next),
    .mdir_l_next (mdir_l_next),
    .mdir_r_next (mdir_r_next),
    .pwm_l       (pwm_l),
    .pwm_r       (pwm_r),
    .mdir_l      (mdir_l),
    .mdir_r      (mdir_r)
  );

endmodule

`default_nettype wire

// File: tb/tb_drive_sequencer.sv
// Bench for drive_sequencer: directed scenarios plus random code streams against a behavioural model.
`default_nettype none

module tb_drive_sequencer;

  localparam int P  = 10;
  localparam int DF = 8;
  localparam int DV = 4;
  localparam int DT = 6;
  localparam int TM = 40;
  localparam int ST = 20;

  localparam int M_IDLE = 0, M_DRIVE = 1, M_TURN = 2, M_HALT = 3, M_DONE = 4;
  localparam int K_PRO = 0, K_VL = 1, K_VR = 2, K_HL = 3, K_HR = 4, K_NL = 5, K_NR = 6, K_STOP = 7;

  logic       clk = 1'b0;
  logic       reset;
  logic       go;
  logic [3:0] laps;
  logic [3:0] dir_code;
  logic       direction, pwm_l, pwm_r, mdir_l, mdir_r, busy, done;

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  drive_sequencer #(
    .PWM_PERIOD   (P),
    .DUTY_FULL    (DF),
    .DUTY_VEER    (DV),
    .DUTY_TURN    (DT),
    .TURN_MIN     (TM),
    .SETTLE_TICKS (ST)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .go        (go),
    .laps      (laps),
    .dir_code  (dir_code),
    .direction (direction),
    .pwm_l     (pwm_l),
    .pwm_r     (pwm_r),
    .mdir_l    (mdir_l),
    .mdir_r    (mdir_r),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         mode;
    logic [3:0] code;
    int         tin;
    int         laps;
    bit         dir;
    bit         left;
    int         cnt;
    int         dl;
    int         dr;
    bit         ml;
    bit         mr;
  } model_t;

  typedef struct {
    int dl;
    int dr;
    bit ml;
    bit mr;
  } cmd_s;

  model_t m;

  function automatic int kind(input logic [3:0] c);
    case (c)
      4'b0000: return K_PRO;
      4'b0101: return K_VL;
      4'b1001: return K_VR;
      4'b0110: return K_HL;
      4'b1010: return K_HR;
      4'b0111: return K_NL;
      4'b1011: return K_NR;
      default: return K_STOP;
    endcase
  endfunction

  // Wheel demand implied by the current mode and steering code.
  function automatic cmd_s command(input int mode, input int k, input bit left, input bit dir);
    cmd_s c;
    c.dl = 0; c.dr = 0; c.ml = 1'b1; c.mr = 1'b1;
    if (mode == M_DRIVE) begin
      case (k)
        K_PRO: begin c.dl = DF; c.dr = DF; end
        K_VL:  begin c.dl = DV; c.dr = DF; end
        K_VR:  begin c.dl = DF; c.dr = DV; end
        K_HL:  begin c.dl = 0;  c.dr = DF; end
        K_HR:  begin c.dl = DF; c.dr = 0;  end
        K_NL:  begin c.dl = DT; c.dr = DT; c.ml = 1'b0; end
        K_NR:  begin c.dl = DT; c.dr = DT; c.mr = 1'b0; end
        default: ;
      endcase
    end else if (mode == M_TURN) begin
      c.dl = DT; c.dr = DT;
      if (left) c.ml = 1'b0; else c.mr = 1'b0;
    end
    if ((mode == M_DRIVE || mode == M_TURN) && !dir) begin
      c.ml = !c.ml;
      c.mr = !c.mr;
    end
    return c;
  endfunction

  function automatic model_t step(input model_t s, input logic rst, input logic g,
                                  input logic [3:0] lp, input logic [3:0] dc);
    model_t n;
    cmd_s   c;
    int     k;
    n = s;
    if (rst) begin
      n.mode = M_IDLE; n.code = 4'd0; n.tin = 0; n.laps = 0; n.dir = 1'b1; n.left = 1'b0;
      n.cnt = 0; n.dl = 0; n.dr = 0; n.ml = 1'b1; n.mr = 1'b1;
      return n;
    end
    k = kind(s.code);
    c = command(s.mode, k, s.left, s.dir);
    case (s.mode)
      M_IDLE, M_DONE: if (g) begin n.mode = M_DRIVE; n.laps = int'(lp); n.dir = 1'b1; end
      M_DRIVE: begin
        if (k == K_STOP) begin n.mode = M_HALT; n.tin = 0; end
        else if (k == K_NL || k == K_NR) begin n.mode = M_TURN; n.tin = 0; n.left = (k == K_NL); end
      end
      M_TURN: begin
        if (k == K_STOP) begin n.mode = M_HALT; n.tin = 0; end
        else if (s.tin >= TM && k != K_NL && k != K_NR) n.mode = M_DRIVE;
        else n.tin = s.tin + 1;
      end
      M_HALT: begin
        if (s.tin == ST - 1) begin
          if (s.laps != 0) begin n.dir = !s.dir; n.laps = s.laps - 1; n.mode = M_DRIVE; end
          else n.mode = M_DONE;
        end else n.tin = s.tin + 1;
      end
      default: ;
    endcase
    if (s.cnt == P - 1) begin n.dl = c.dl; n.dr = c.dr; n.ml = c.ml; n.mr = c.mr; end
    if (n.mode == M_HALT || n.mode == M_IDLE || n.mode == M_DONE) begin n.dl = 0; n.dr = 0; end
    n.cnt  = (s.cnt + 1) % P;
    n.code = dc;
    return n;
  endfunction

  always @(posedge clk) m <= step(m, reset, go, laps, dir_code);

  function automatic logic [6:0] expected(input model_t s);
    return {s.cnt < s.dl, s.cnt < s.dr, s.ml, s.mr, s.dir,
            (s.mode == M_DRIVE || s.mode == M_TURN || s.mode == M_HALT), s.mode == M_DONE};
  endfunction

  wire [6:0] outs = {pwm_l, pwm_r, mdir_l, mdir_r, direction, busy, done};

  always @(negedge clk) begin
    if (check_en) begin
      tests++;
      if (outs !== expected(m)) begin
        fails++;
        $display("FAIL cycle_outputs t=%0t: got %b expected %b (pwm_l pwm_r mdir_l mdir_r dir busy done)",
                 $time, outs, expected(m));
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic count_high(output int cl, output int cr);
    cl = 0; cr = 0;
    for (int i = 0; i < P; i++) begin
      @(negedge clk);
      cl += int'(pwm_l);
      cr += int'(pwm_r);
    end
  endtask

  logic [3:0] codes [10] = '{4'b0000, 4'b1001, 4'b1010, 4'b0101, 4'b0110,
                             4'b0111, 4'b1011, 4'b1111, 4'b0001, 4'b1100};

  initial begin
    int cl, cr;
    reset = 1'b1; go = 1'b0; laps = 4'd0; dir_code = 4'b0000;
    repeat (3) @(negedge clk);
    check_en = 1'b1;
    check("reset_outputs", 32'(outs), 32'(7'b0011100));
    reset = 1'b0;

    // Straight drive.
    go = 1'b1; laps = 4'd0;
    @(negedge clk);
    go = 1'b0;
    check("busy_after_go", 32'(busy), 32'd1);
    repeat (11) @(negedge clk);
    count_high(cl, cr);
    check("proceed_duty_l", cl, 8);
    check("proceed_duty_r", cr, 8);
    check("proceed_mdir", 32'({mdir_l, mdir_r, direction}), 32'(3'b111));

    // Veer left.
    dir_code = 4'b0101;
    repeat (13) @(negedge clk);
    count_high(cl, cr);
    check("veer_l_duty_l", cl, 4);
    check("veer_l_duty_r", cr, 8);

    // Left pivot released early: must still hold for the minimum time.
    dir_code = 4'b0111;
    repeat (10) @(negedge clk);
    dir_code = 4'b0000;
    repeat (20) @(negedge clk);
    check("pivot_mdir", 32'({mdir_l, mdir_r}), 32'(2'b01));
    count_high(cl, cr);
    check("pivot_duty_l", cl, 6);
    check("pivot_duty_r", cr, 6);
    repeat (25) @(negedge clk);
    check("after_pivot_mdir", 32'({mdir_l, mdir_r}), 32'(2'b11));

    // Undefined code halts, no laps left so DONE follows.
    dir_code = 4'b0001;
    repeat (2) @(negedge clk);
    check("undef_pwm_low", 32'({pwm_l, pwm_r}), 32'd0);
    check("undef_busy", 32'(busy), 32'd1);
    dir_code = 4'b0000;
    repeat (21) @(negedge clk);
    check("undef_done", 32'({done, busy}), 32'(2'b10));

    // One lap: stop, reverse, stop again.
    go = 1'b1; laps = 4'd1;
    @(negedge clk);
    go = 1'b0;
    repeat (12) @(negedge clk);
    dir_code = 4'b1111;
    repeat (2) @(negedge clk);
    check("stop_pwm_low", 32'({pwm_l, pwm_r}), 32'd0);
    dir_code = 4'b0000;
    repeat (21) @(negedge clk);
    check("reversed_dir", 32'({direction, busy}), 32'(2'b01));
    go = 1'b1; laps = 4'd7;
    @(negedge clk);
    go = 1'b0;
    repeat (10) @(negedge clk);
    check("reverse_mdir", 32'({mdir_l, mdir_r}), 32'(2'b00));
    dir_code = 4'b1111;
    repeat (2) @(negedge clk);
    dir_code = 4'b0000;
    repeat (21) @(negedge clk);
    check("lap_done", 32'({done, busy}), 32'(2'b10));

    // Reset in the middle of a right pivot.
    go = 1'b1; laps = 4'd0;
    @(negedge clk);
    go = 1'b0;
    dir_code = 4'b1011;
    repeat (8) @(negedge clk);
    reset = 1'b1; dir_code = 4'b0000;
    @(negedge clk);
    reset = 1'b0;
    check("reset_mid_turn", 32'(outs), 32'(7'b0011100));

    // Random code streams with occasional go and reset pulses.
    for (int seg = 0; seg < 250; seg++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) reset = 1'b1;
      else if (r < 12 || (r < 60 && (m.mode == M_IDLE || m.mode == M_DONE))) begin
        go = 1'b1;
        laps = 4'($urandom_range(0, 2));
      end
      r = $urandom_range(0, 99);
      if (r < 55)      dir_code = codes[$urandom_range(0, 4)];
      else if (r < 80) dir_code = codes[$urandom_range(5, 6)];
      else             dir_code = codes[$urandom_range(7, 9)];
      @(negedge clk);
      reset = 1'b0; go = 1'b0;
      repeat ($urandom_range(0, 50)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
